triad_arbiter: RTL and testbench

TRIAD_ARBITER -- requirements
Module: triad_arbiter

---
 rtl/triad_arbiter_if.sv | 31 +++
 rtl/triad_arbiter.sv | 110 +++++++++++
 tb/tb_triad_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/triad_arbiter_if.sv
// Triad arbiter bus: capture strobes/records from the triad managers and the
// presented record toward the serial transmitter.
interface triad_arbiter_if #(
   parameter int unsigned DATA_W = 68
);
   logic [2:0]        en_mask;
   logic              data_avl_0;
   logic              data_avl_1;
   logic              data_avl_2;
   logic [DATA_W-1:0] triad_data_0;
   logic [DATA_W-1:0] triad_data_1;
   logic [DATA_W-1:0] triad_data_2;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_id;
   logic [7:0]        drop_count;
   logic [2:0]        pending;

   modport master (
      output en_mask, data_avl_0, data_avl_1, data_avl_2,
             triad_data_0, triad_data_1, triad_data_2, out_ready,
      input  out_valid, out_data, out_id, drop_count, pending
   );

   modport slave (
      input  en_mask, data_avl_0, data_avl_1, data_avl_2,
             triad_data_0, triad_data_1, triad_data_2, out_ready,
      output out_valid, out_data, out_id, drop_count, pending
   );
endinterface

// File: rtl/triad_arbiter.sv
// Round-robin arbiter: one holding register per triad, presents one record at a
// time to the transmitter and counts records overwritten before transmission.
module triad_arbiter #(
   parameter int unsigned NUM_TRIADS = 3,
   parameter int unsigned DATA_W     = 68
) (
   input  logic             clk_96MHz,
   input  logic             rst_n,
   triad_arbiter_if.slave   bus
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t                state_q;
   logic [DATA_W-1:0]     hold_q [NUM_TRIADS];
   logic [NUM_TRIADS-1:0] pend_q;
   logic [1:0]            rr_q;
   logic                  out_valid_q;
   logic [DATA_W-1:0]     out_data_q;
   logic [1:0]            out_id_q;
   logic [7:0]            drop_cnt_q;
   logic [7:0]            drop_cnt_d;

   logic [DATA_W-1:0]     din [NUM_TRIADS];
   logic [NUM_TRIADS-1:0] cap;
   logic [NUM_TRIADS-1:0] gnt;
   logic [NUM_TRIADS-1:0] drop_v;
   logic                  gnt_vld;
   logic [1:0]            gnt_idx;
   logic [2:0]            srch;
   logic [1:0]            drop_n;
   logic [8:0]            cnt_sum;

   assign din[0] = bus.triad_data_0;
   assign din[1] = bus.triad_data_1;
   assign din[2] = bus.triad_data_2;
   assign cap    = {bus.data_avl_2, bus.data_avl_1, bus.data_avl_0} & bus.en_mask;

   // First pending triad scanning upward from rr_q, wrapping modulo NUM_TRIADS.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      srch    = '0;
      if (state_q == IDLE) begin
         for (int unsigned k = 0; k < NUM_TRIADS; k++) begin
            srch = {1'b0, rr_q} + 3'(k);
            if (srch >= 3'(NUM_TRIADS)) srch = srch - 3'(NUM_TRIADS);
            if (!gnt_vld && pend_q[srch[1:0]]) begin
               gnt_vld = 1'b1;
               gnt_idx = srch[1:0];
            end
         end
      end
      gnt = gnt_vld ? (NUM_TRIADS'(1) << gnt_idx) : '0;
   end

   // A capture onto a triad granted this cycle replaces nothing that is lost.
   assign drop_v = cap & pend_q & ~gnt;

   always_comb begin
      drop_n = '0;
      for (int unsigned i = 0; i < NUM_TRIADS; i++) drop_n = drop_n + {1'b0, drop_v[i]};
      cnt_sum    = {1'b0, drop_cnt_q} + {7'b0, drop_n};
      drop_cnt_d = cnt_sum[8] ? '1 : cnt_sum[7:0];
   end

   always_ff @(posedge clk_96MHz) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         drop_cnt_q  <= '0;
         for (int unsigned i = 0; i < NUM_TRIADS; i++) hold_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_TRIADS; i++) begin
            if (cap[i]) hold_q[i] <= din[i];
         end
         pend_q     <= cap | (pend_q & ~gnt);
         drop_cnt_q <= drop_cnt_d;
         case (state_q)
            IDLE: begin
               if (gnt_vld) begin
                  out_data_q  <= hold_q[gnt_idx];
                  out_id_q    <= gnt_idx;
                  out_valid_q <= 1'b1;
                  state_q     <= PRESENT;
               end
            end
            PRESENT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  rr_q        <= (out_id_q == 2'd2) ? 2'd0 : out_id_q + 2'd1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_id     = out_id_q;
   assign bus.drop_count = drop_cnt_q;
   assign bus.pending    = pend_q;

endmodule

// File: tb/tb_triad_arbiter.sv
// Directed vector bench for triad_arbiter: per-cycle table plus hand sequences
// for reset-while-presenting and drop counter saturation.
module tb_triad_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   triad_arbiter_if #(.DATA_W(68)) bus ();

   triad_arbiter #(.NUM_TRIADS(3), .DATA_W(68)) dut (
      .clk_96MHz (clk),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   typedef struct {
      string       nm;
      logic        rst;
      logic [2:0]  en;
      logic [2:0]  avl;
      logic [67:0] d0, d1, d2;
      logic        rdy;
      logic        ev;
      logic [1:0]  eid;
      logic [67:0] edat;
      logic [7:0]  edrop;
      logic [2:0]  epend;
      logic        cd;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(string nm, logic rst, logic [2:0] en, logic [2:0] avl,
                              logic [67:0] d0, logic [67:0] d1, logic [67:0] d2, logic rdy,
                              logic ev, logic [1:0] eid, logic [67:0] edat,
                              logic [7:0] edrop, logic [2:0] epend, logic cd);
      vec_t r;
      r.nm = nm; r.rst = rst; r.en = en; r.avl = avl; r.d0 = d0; r.d1 = d1; r.d2 = d2;
      r.rdy = rdy; r.ev = ev; r.eid = eid; r.edat = edat; r.edrop = edrop;
      r.epend = epend; r.cd = cd;
      return r;
   endfunction

   task automatic chk(string nm, logic [67:0] act, logic [67:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic rst, logic [2:0] en, logic [2:0] avl, logic [67:0] d0,
                        logic [67:0] d1, logic [67:0] d2, logic rdy);
      rst_n            = rst;
      bus.en_mask      = en;
      bus.data_avl_0   = avl[0];
      bus.data_avl_1   = avl[1];
      bus.data_avl_2   = avl[2];
      bus.triad_data_0 = d0;
      bus.triad_data_1 = d1;
      bus.triad_data_2 = d2;
      bus.out_ready    = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, 3'b111, 3'b000, '0, '0, '0, 1'b0);

      //        name        rst en  avl d0  d1     d2  rdy  ev id data   drop pend cd
      tv.push_back(v("reset",    0, 7, 0, 0,  0,     0,  0,   0, 0, 0,     0,   0,   1));
      tv.push_back(v("rst_cap",  0, 7, 7, 5,  6,     7,  1,   0, 0, 0,     0,   0,   1));
      tv.push_back(v("burst1",   1, 7, 7, 10, 11,    12, 1,   0, 0, 0,     0,   7,   0));
      tv.push_back(v("rr_a0",    1, 7, 0, 0,  0,     0,  1,   1, 0, 10,    0,   6,   1));
      tv.push_back(v("xfer_a0",  1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   6,   0));
      tv.push_back(v("rr_a1",    1, 7, 0, 0,  0,     0,  1,   1, 1, 11,    0,   4,   1));
      tv.push_back(v("xfer_a1",  1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   4,   0));
      tv.push_back(v("rr_a2",    1, 7, 0, 0,  0,     0,  1,   1, 2, 12,    0,   0,   1));
      tv.push_back(v("burst2",   1, 7, 7, 20, 21,    22, 1,   0, 0, 0,     0,   7,   0));
      tv.push_back(v("rr_b0",    1, 7, 0, 0,  0,     0,  1,   1, 0, 20,    0,   6,   1));
      tv.push_back(v("xfer_b0",  1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   6,   0));
      tv.push_back(v("rr_b1",    1, 7, 0, 0,  0,     0,  1,   1, 1, 21,    0,   4,   1));
      tv.push_back(v("xfer_b1",  1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   4,   0));
      tv.push_back(v("rr_b2",    1, 7, 0, 0,  0,     0,  1,   1, 2, 22,    0,   0,   1));
      tv.push_back(v("xfer_b2",  1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   0,   0));
      tv.push_back(v("single_c", 1, 7, 2, 0,  'hA5,  0,  1,   0, 0, 0,     0,   2,   0));
      tv.push_back(v("single_p", 1, 7, 0, 0,  0,     0,  1,   1, 1, 'hA5,  0,   0,   1));
      tv.push_back(v("single_x", 1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   0,   0));
      tv.push_back(v("idle_rdy", 1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   0,   0));
      tv.push_back(v("masked",   1, 5, 2, 0,  'h33,  0,  1,   0, 0, 0,     0,   0,   0));
      tv.push_back(v("masked2",  1, 5, 0, 0,  0,     0,  1,   0, 0, 0,     0,   0,   0));
      tv.push_back(v("pre_mask", 1, 7, 1, 'h44, 0,   0,  0,   0, 0, 0,     0,   1,   0));
      tv.push_back(v("mask_pnd", 1, 6, 0, 0,  0,     0,  0,   1, 0, 'h44,  0,   0,   1));
      tv.push_back(v("stable",   1, 7, 0, 0,  0,     0,  0,   1, 0, 'h44,  0,   0,   1));
      tv.push_back(v("xfer_m",   1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     0,   0,   0));
      tv.push_back(v("ovf_1",    1, 7, 4, 0,  0,     1,  0,   0, 0, 0,     0,   4,   0));
      tv.push_back(v("ovf_2",    1, 7, 4, 0,  0,     2,  0,   1, 2, 1,     0,   4,   1));
      tv.push_back(v("ovf_3",    1, 7, 4, 0,  0,     3,  0,   1, 2, 1,     1,   4,   1));
      tv.push_back(v("ovf_x1",   1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     1,   4,   0));
      tv.push_back(v("ovf_p3",   1, 7, 0, 0,  0,     0,  1,   1, 2, 3,     1,   0,   1));
      tv.push_back(v("ovf_x3",   1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     1,   0,   0));
      tv.push_back(v("multi_1",  1, 7, 7, 50, 51,    52, 0,   0, 0, 0,     1,   7,   0));
      tv.push_back(v("multi_2",  1, 7, 7, 60, 61,    62, 0,   1, 0, 50,    3,   7,   1));
      tv.push_back(v("multi_3",  1, 7, 3, 70, 71,    0,  0,   1, 0, 50,    5,   7,   1));
      tv.push_back(v("multi_x",  1, 7, 0, 0,  0,     0,  1,   0, 0, 0,     5,   7,   0));
      tv.push_back(v("multi_p1", 1, 7, 0, 0,  0,     0,  1,   1, 1, 71,    5,   5,   1));

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rst, tv[i].en, tv[i].avl, tv[i].d0, tv[i].d1, tv[i].d2, tv[i].rdy);
         step();
         chk({tv[i].nm, ".valid"}, 68'(bus.out_valid), 68'(tv[i].ev));
         chk({tv[i].nm, ".pending"}, 68'(bus.pending), 68'(tv[i].epend));
         chk({tv[i].nm, ".drop"}, 68'(bus.drop_count), 68'(tv[i].edrop));
         if (tv[i].cd) begin
            chk({tv[i].nm, ".id"}, 68'(bus.out_id), 68'(tv[i].eid));
            chk({tv[i].nm, ".data"}, bus.out_data, tv[i].edat);
         end
      end

      // Reset while presenting the triad-1 record; nothing is counted as dropped.
      drive(1'b0, 3'b111, 3'b000, '0, '0, '0, 1'b0);
      step();
      chk("rstp.valid", 68'(bus.out_valid), 68'd0);
      chk("rstp.data", bus.out_data, 68'd0);
      chk("rstp.id", 68'(bus.out_id), 68'd0);
      chk("rstp.drop", 68'(bus.drop_count), 68'd0);
      chk("rstp.pending", 68'(bus.pending), 68'd0);
      drive(1'b1, 3'b111, 3'b000, '0, '0, '0, 1'b1);
      step();
      chk("rstp_after.valid", 68'(bus.out_valid), 68'd0);
      chk("rstp_after.pending", 68'(bus.pending), 68'd0);

      // Continuous strobes on triad 0 with the transmitter stalled.
      for (int k = 1; k <= 300; k++) begin
         drive(1'b1, 3'b111, 3'b001, 68'(k), '0, '0, 1'b0);
         step();
         if (k == 200) chk("sat.k200", 68'(bus.drop_count), 68'd198);
         if (k == 256) chk("sat.k256", 68'(bus.drop_count), 68'd254);
         if (k == 257) chk("sat.k257", 68'(bus.drop_count), 68'd255);
      end
      chk("sat.k300", 68'(bus.drop_count), 68'd255);
      chk("sat.valid", 68'(bus.out_valid), 68'd1);
      chk("sat.data", bus.out_data, 68'd1);
      drive(1'b1, 3'b111, 3'b000, '0, '0, '0, 1'b1);
      step();
      chk("sat.hold", 68'(bus.drop_count), 68'd255);
      step();
      chk("sat.last.valid", 68'(bus.out_valid), 68'd1);
      chk("sat.last.data", bus.out_data, 68'd300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
